// File: rtl/inference_pkg.sv
// Shared constants and writer state encoding for the inference BRAM write-back path.
package inference_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned ADDR_STEP = 4;

    localparam logic [WORD_W-1:0] MARKER_DONE = 32'hFFFF_FF00;
    localparam logic [WORD_W-1:0] MARKER_WAIT = 32'hFFFF_FFFF;
    localparam logic [TAG_W-1:0]  RESULT_TAG  = 8'hA5;
    localparam logic [TAG_W-1:0]  CHECK_TAG   = 8'hC5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_MARK    = 3'd4,
        ST_DONE    = 3'd5
    } writer_state_e;

    // Checksum word: tag in the top byte, XOR of classes in the bottom byte.
    function automatic logic [WORD_W-1:0] check_word(input logic [TAG_W-1:0] csum);
        return {CHECK_TAG, 16'h0000, csum};
    endfunction

endpackage

// File: rtl/inference_result_writer_if.sv
// Result handoff from the inference core plus the BRAM write port and status.
interface inference_result_writer_if #(
    parameter int unsigned CLASS_LEN = 4,
    parameter int unsigned IMAGES    = 8
);
    logic                             result_ready;
    logic [IMAGES-1:0][CLASS_LEN-1:0] predicted_class;
    logic [31:0]                      base_addr;
    logic [31:0]                      addra;
    logic [31:0]                      dina;
    logic                             ena;
    logic [3:0]                       wea;
    logic                             busy;
    logic                             done;

    // Writer side: consumes results, drives the BRAM port.
    modport master (
        input  result_ready, predicted_class, base_addr,
        output addra, dina, ena, wea, busy, done
    );

    // Environment side: inference core, BRAM and host status.
    modport slave (
        output result_ready, predicted_class, base_addr,
        input  addra, dina, ena, wea, busy, done
    );
endinterface

// File: rtl/inference_result_writer_result_word_pack.sv
// Packs (image index, predicted class) into a tagged 32-bit result word.
module result_word_pack
    import inference_pkg::*;
#(
    parameter int unsigned CLASS_LEN = 4
) (
    input  logic [7:0]           i_index,
    input  logic [CLASS_LEN-1:0] i_class,
    output logic [WORD_W-1:0]    o_word_c
);

    // The A5 tag keeps every data word distinct from the FFFF_FFxx markers.
    assign o_word_c = {RESULT_TAG, i_index, 16'(i_class)};

endmodule

// File: rtl/inference_result_writer.sv
// Writes captured per-image classes as tagged words into BRAM, then the completion marker.
// Optional checksum word before the marker: define INFERENCE_RESULT_CHECKSUM_EN.
module inference_result_writer
    import inference_pkg::*;
#(
    parameter int unsigned CLASS_LEN = 4,
    parameter int unsigned IMAGES    = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    inference_result_writer_if.master  bus
);

    localparam int unsigned IDX_W = (IMAGES > 1) ? $clog2(IMAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMAGES - 1);

`ifdef INFERENCE_RESULT_CHECKSUM_EN
    localparam writer_state_e AFTER_WRITE = ST_CHECK;
`else
    localparam writer_state_e AFTER_WRITE = ST_MARK;
`endif

    writer_state_e                    r_state;
    logic                             r_rr_prev;
    logic [IMAGES-1:0][CLASS_LEN-1:0] r_classes;
    logic [31:0]                      r_addr;
    logic [IDX_W-1:0]                 r_idx;
    logic [31:0]                      r_addra;
    logic [31:0]                      r_dina;
    logic                             r_ena;
    logic [3:0]                       r_wea;
    logic                             r_busy;
    logic                             r_done;
`ifdef INFERENCE_RESULT_CHECKSUM_EN
    logic [7:0]                       r_csum;
`endif

    logic [CLASS_LEN-1:0] w_class;
    logic [31:0]          w_word;

    assign w_class = r_classes[r_idx];

    result_word_pack #(
        .CLASS_LEN (CLASS_LEN)
    ) u_pack (
        .i_index  (8'(r_idx)),
        .i_class  (w_class),
        .o_word_c (w_word)
    );

    // Sequencer; the write strobes default low so each state drives at most one word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rr_prev <= 1'b0;
            r_classes <= '0;
            r_addr    <= '0;
            r_idx     <= '0;
            r_addra   <= '0;
            r_dina    <= '0;
            r_ena     <= 1'b0;
            r_wea     <= 4'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef INFERENCE_RESULT_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_rr_prev <= bus.result_ready;
            r_ena     <= 1'b0;
            r_wea     <= 4'h0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.result_ready && !r_rr_prev) begin
                        r_state <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    r_classes <= bus.predicted_class;
                    r_addr    <= bus.base_addr;
                    r_idx     <= '0;
`ifdef INFERENCE_RESULT_CHECKSUM_EN
                    r_csum    <= '0;
`endif
                    r_busy    <= 1'b1;
                    r_state   <= ST_WRITE;
                end

                ST_WRITE: begin
                    r_addra <= r_addr;
                    r_dina  <= w_word;
                    r_ena   <= 1'b1;
                    r_wea   <= 4'hF;
                    r_addr  <= r_addr + 32'(ADDR_STEP);
`ifdef INFERENCE_RESULT_CHECKSUM_EN
                    r_csum  <= r_csum ^ 8'(w_class);
`endif
                    if (r_idx == LAST_IDX) begin
                        r_state <= AFTER_WRITE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

`ifdef INFERENCE_RESULT_CHECKSUM_EN
                ST_CHECK: begin
                    r_addra <= r_addr;
                    r_dina  <= check_word(r_csum);
                    r_ena   <= 1'b1;
                    r_wea   <= 4'hF;
                    r_addr  <= r_addr + 32'(ADDR_STEP);
                    r_state <= ST_MARK;
                end
`endif

                ST_MARK: begin
                    r_addra <= r_addr;
                    r_dina  <= MARKER_DONE;
                    r_ena   <= 1'b1;
                    r_wea   <= 4'hF;
                    r_state <= ST_DONE;
                end

                // First cycle raises done; afterwards wait for result_ready to drop.
                ST_DONE: begin
                    if (!r_done) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else if (!bus.result_ready) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addra = r_addra;
    assign bus.dina  = r_dina;
    assign bus.ena   = r_ena;
    assign bus.wea   = r_wea;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_inference_result_writer.sv
// Self-checking bench for inference_result_writer with a word-list reference model.
module tb_inference_result_writer;

    localparam int unsigned CLASS_LEN = 4;
    localparam int unsigned IMAGES    = 8;
`ifdef INFERENCE_RESULT_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    inference_result_writer_if #(.CLASS_LEN(CLASS_LEN), .IMAGES(IMAGES)) bus ();

    inference_result_writer #(
        .CLASS_LEN (CLASS_LEN),
        .IMAGES    (IMAGES)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cls[IMAGES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return 32'hA500_0000 + (32'(i) * 32'h0001_0000) + 32'(cls[i]);
    endfunction

    function automatic logic [31:0] model_csum();
        int x = 0;
        for (int i = 0; i < int'(IMAGES); i++) x = x ^ cls[i];
        return 32'hC500_0000 + 32'(x);
    endfunction

    task automatic drive_classes(input bit junk);
        for (int i = 0; i < int'(IMAGES); i++)
            bus.predicted_class[i] = junk ? CLASS_LEN'($urandom) : CLASS_LEN'(cls[i]);
    endtask

    task automatic randomize_classes();
        for (int i = 0; i < int'(IMAGES); i++) cls[i] = int'($urandom_range(0, (1 << CLASS_LEN) - 1));
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_ena"}, 32'(bus.ena), 32'd0);
        chk({tag, "_wea"}, 32'(bus.wea), 32'd0);
    endtask

    // mode 0: drop after done, 1: drop mid-write, 2: hold high after done, 3: reset at word 2
    task automatic run_seq(input logic [31:0] base, input int mode);
        int          total;
        int          w;
        logic [31:0] exp_data;
        total = 4 + int'(IMAGES) + int'(EXTRA);
        @(posedge clock); #1;
        bus.base_addr    = base;
        drive_classes(1'b0);
        bus.result_ready = 1'b1;
        for (int e = 1; e <= total; e++) begin
            @(posedge clock); #1;
            if (e <= 2) begin
                chk_idle_port("pre");
                chk("pre_busy", 32'(bus.busy), 32'(e == 2));
                chk("pre_done", 32'(bus.done), 32'd0);
            end else if (e < total) begin
                w = e - 3;
                if (w < int'(IMAGES))                   exp_data = model_word(w);
                else if (EXTRA == 1 && w == int'(IMAGES)) exp_data = model_csum();
                else                                     exp_data = 32'hFFFF_FF00;
                chk("wr_ena",   32'(bus.ena),  32'd1);
                chk("wr_wea",   32'(bus.wea),  32'hF);
                chk("wr_busy",  32'(bus.busy), 32'd1);
                chk("wr_done",  32'(bus.done), 32'd0);
                chk("wr_addra", bus.addra, base + 32'(4 * w));
                chk("wr_dina",  bus.dina,  exp_data);
                if (e == 3) drive_classes(1'b1);
                if (mode == 1 && e == 5) bus.result_ready = 1'b0;
                if (mode == 3 && e == 5) begin
                    reset_n = 1'b0;
                    #1;
                    chk_idle_port("rst");
                    chk("rst_busy",  32'(bus.busy), 32'd0);
                    chk("rst_done",  32'(bus.done), 32'd0);
                    chk("rst_addra", bus.addra, 32'd0);
                    chk("rst_dina",  bus.dina,  32'd0);
                    bus.result_ready = 1'b0;
                    repeat (3) begin
                        @(posedge clock); #1;
                        chk_idle_port("in_rst");
                    end
                    reset_n = 1'b1;
                    repeat (3) begin
                        @(posedge clock); #1;
                        chk_idle_port("post_rst");
                        chk("post_rst_busy", 32'(bus.busy), 32'd0);
                    end
                    return;
                end
            end else begin
                chk_idle_port("fin");
                chk("fin_busy", 32'(bus.busy), 32'd0);
                chk("fin_done", 32'(bus.done), 32'd1);
            end
        end
        if (mode == 2) begin
            repeat (4) begin
                drive_classes(1'b1);
                @(posedge clock); #1;
                chk_idle_port("hold");
                chk("hold_done", 32'(bus.done), 32'd1);
                chk("hold_busy", 32'(bus.busy), 32'd0);
            end
        end
        bus.result_ready = 1'b0;
        @(posedge clock); #1;
        chk_idle_port("after");
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.result_ready    = 1'b0;
        bus.predicted_class = '0;
        bus.base_addr       = '0;
        reset_n             = 1'b0;
        #12;
        chk_idle_port("reset");
        chk("reset_busy",  32'(bus.busy), 32'd0);
        chk("reset_done",  32'(bus.done), 32'd0);
        chk("reset_addra", bus.addra, 32'd0);
        chk("reset_dina",  bus.dina,  32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed: classes 0..7 at 0x100
        for (int i = 0; i < int'(IMAGES); i++) cls[i] = i;
        run_seq(32'h0000_0100, 0);

        // Drop result_ready mid-write
        randomize_classes();
        run_seq(32'($urandom) & 32'hFFFF_FFFC, 1);

        // Hold high after done with class changes, then a fresh run
        randomize_classes();
        run_seq(32'h0000_0200, 2);
        randomize_classes();
        run_seq(32'h0000_0200, 0);

        // Address wrap
        randomize_classes();
        run_seq(32'hFFFF_FFF8, 0);

        // Reset at the third data write, then restart from word 0
        randomize_classes();
        run_seq(32'h0000_0400, 3);
        randomize_classes();
        run_seq(32'h0000_0400, 0);

`ifdef INFERENCE_RESULT_CHECKSUM_EN
        cls = '{1, 2, 4, 8, 0, 0, 0, 0};
        run_seq(32'h0000_0100, 0);
`endif

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            randomize_classes();
            run_seq(32'($urandom) & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
